// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing the write port of one async FIFO among NUM_REQ
// requesters. Lives in the wclk domain. Each grant allows a burst of up to
// MAX_BURST words, and the FIFO is never written while wfull is high.
//
// Ports:
//   wclk       write-side clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester word available
//   req_data   requester i word at [i*WIDTH +: WIDTH]
//   req_ready  per-requester word accepted this cycle
//   wfull      FIFO full flag (wclk domain)
//   wr_en      FIFO write enable
//   din        FIFO write data (zero when not writing)
//   grant      registered one-hot grant, zero when idle
//   busy       high while a burst is in progress
//
// Optional: define WR_ARB_STATS_EN to add the saturating 16-bit counters
// words_written and full_stall_cycles.
//
// state | meaning
// IDLE  | no grant; pick the next requester in rotation (costs one cycle)
// BURST | grant held; words transfer whenever granted valid and not full
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     wclk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     wfull,
    output logic                     wr_en,
    output logic [WIDTH-1:0]         din,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [15:0]              words_written,
    output logic [15:0]              full_stall_cycles
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic [PTR_W-1:0]   last_ptr_q, last_ptr_d;

    logic [PTR_W-1:0]   sel;
    logic               sel_found;
    logic               granted_valid;

    // Scan cyclically starting just after the last served requester.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] idx_p;
        sel       = last_ptr_q;
        sel_found = 1'b0;
        idx       = 0;
        idx_p     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx   = (int'(last_ptr_q) + k) % NUM_REQ;
            idx_p = PTR_W'(idx);
            if (!sel_found && req_valid[idx_p]) begin
                sel       = idx_p;
                sel_found = 1'b1;
            end
        end
    end

    assign granted_valid = |(grant_q & req_valid);
    // grant_q is all-zero outside BURST, so no state qualifier is needed here.
    assign req_ready     = grant_q & req_valid & {NUM_REQ{~wfull}};
    assign wr_en         = |req_ready;
    assign grant         = grant_q;
    assign busy          = (state_q == BURST);

    always_comb begin
        din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                din = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        last_ptr_d  = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d     = BURST;
                    grant_d     = NUM_REQ'(1) << sel;
                    last_ptr_d  = sel;
                    burst_cnt_d = '0;
                end
            end
            BURST: begin
                if (!granted_valid) begin
                    // Requester let go: forfeit the rest of the burst.
                    state_d     = IDLE;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                end else if (wr_en) begin
                    if (burst_cnt_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            last_ptr_q  <= PTR_RST;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            last_ptr_q  <= last_ptr_d;
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [15:0] words_written_q, words_written_d;
    logic [15:0] full_stall_q, full_stall_d;

    always_comb begin
        words_written_d = words_written_q;
        full_stall_d    = full_stall_q;
        if (wr_en && (words_written_q != 16'hFFFF)) begin
            words_written_d = words_written_q + 16'd1;
        end
        if ((state_q == BURST) && wfull && granted_valid && (full_stall_q != 16'hFFFF)) begin
            full_stall_d = full_stall_q + 16'd1;
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            words_written_q <= '0;
            full_stall_q    <= '0;
        end else begin
            words_written_q <= words_written_d;
            full_stall_q    <= full_stall_d;
        end
    end

    assign words_written     = words_written_q;
    assign full_stall_cycles = full_stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: randomized and directed stimulus checked
// every cycle against a transaction-level model (owner index, words taken,
// rotation pointer) plus an ideal 13-deep FIFO queue.
module tb_fifo_wr_arbiter;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 13;

    logic           wclk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           wfull;
    logic           wr_en;
    logic [W-1:0]   din;
    logic [N-1:0]   grant;
    logic           busy;

    fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .wclk      (wclk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .wr_en     (wr_en),
        .din       (din),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_last  = N - 1;
    logic [N-1:0] m_ready = '0;
    logic [W-1:0] mdl_q[$];
    logic [W-1:0] act_q[$];

    // Stimulus state
    int n[N];
    int lim[N];
    bit en[N];
    bit drain_en   = 1'b1;
    bit force_full = 1'b0;
    bit rand_mode  = 1'b0;

    always @(negedge wclk) begin
        logic [N-1:0] e_grant;
        logic [N-1:0] e_ready;
        logic [W-1:0] e_din;
        logic         e_busy;
        logic         e_wr;
        e_grant = '0;
        e_ready = '0;
        e_din   = '0;
        e_busy  = 1'b0;
        if (!rst && m_owner >= 0) begin
            e_busy           = 1'b1;
            e_grant[m_owner] = 1'b1;
            if (req_valid[m_owner] && !wfull) begin
                e_ready[m_owner] = 1'b1;
                e_din            = req_data[m_owner*W +: W];
            end
        end
        e_wr = |e_ready;
        check("grant", 32'(grant), 32'(e_grant));
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("wr_en", 32'(wr_en), 32'(e_wr));
        check("din", 32'(din), 32'(e_din));
        check("busy", 32'(busy), 32'(e_busy));
        if (e_wr) mdl_q.push_back(e_din);
        m_ready = e_ready;
        if (rst) begin
            m_owner = -1;
            m_cnt   = 0;
            m_last  = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && req_valid[c]) m_owner = c;
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_cnt  = 0;
            end
        end else if (!req_valid[m_owner]) begin
            m_owner = -1;
        end else if (e_wr) begin
            m_cnt++;
            if (m_cnt == MB) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    end

    // What actually reaches the FIFO
    always @(posedge wclk) begin
        if (wr_en) begin
            check("no_overflow", 32'(act_q.size() < DEPTH), 32'd1);
            act_q.push_back(din);
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
        for (int i = 0; i < N; i++) if (m_ready[i]) n[i]++;
        if (drain_en && mdl_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            if (act_q.size() == 0) begin
                check("fifo_nonempty", 32'd0, 32'd1);
                void'(mdl_q.pop_front());
            end else begin
                check("drain_order", 32'(act_q.pop_front()), 32'(mdl_q.pop_front()));
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) en[i] = ~en[i];
                lim[i] = n[i] + 100;
            end
            force_full = ($urandom_range(0, 9) == 0);
        end
        wfull = force_full || (mdl_q.size() >= DEPTH);
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = en[i] && (n[i] < lim[i]);
            req_data[i*W +: W] = W'(16 * i + n[i]);
        end
    endtask

    task automatic do_reset();
        check("fifo_words", 32'(act_q.size()), 32'(mdl_q.size()));
        rst = 1'b1;
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        force_full = 1'b0;
        rand_mode  = 1'b0;
        drain_en   = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        @(negedge wclk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_din", 32'(din), 32'd0);
        act_q.delete();
        mdl_q.delete();
        step();
        rst = 1'b0;
    endtask

    logic [9:0]   t2_pat = 10'b11_1101_1110;
    logic [N-1:0] t3_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] t5_exp[3] = '{4'b1000, 4'b0010, 4'b0100};
    logic [N-1:0] gq[$];
    logic [N-1:0] prev;

    initial begin
        int  w;
        int  cnt;
        bit  done;
        bit  e;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        wfull     = 1'b0;
        for (int i = 0; i < N; i++) begin
            n[i]   = 0;
            lim[i] = 0;
            en[i]  = 1'b0;
        end
        repeat (2) @(negedge wclk);
        do_reset();

        // Single requester, 8 words: two bursts of 4 separated by one IDLE cycle
        en[0]  = 1'b1;
        lim[0] = 8;
        step();
        w = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge wclk);
            e = (c < 10) ? t2_pat[c] : 1'b0;
            check("t2_wr_en", 32'(wr_en), 32'(e));
            if (c == 1) check("t2_grant", 32'(grant), 32'd1);
            if (wr_en) begin
                check("t2_din", 32'(din), 32'(w));
                w++;
            end
            step();
        end
        check("t2_words", 32'(w), 32'd8);

        // All four valid: strict rotation starting at requester 0
        do_reset();
        for (int i = 0; i < N; i++) begin
            en[i]  = 1'b1;
            lim[i] = n[i] + 8;
        end
        gq.delete();
        prev = '0;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge wclk);
            if (grant != '0 && prev == '0) gq.push_back(grant);
            prev = grant;
            step();
            done = 1'b1;
            for (int i = 0; i < N; i++) if (n[i] < lim[i]) done = 1'b0;
        end
        check("t3_done", 32'(done), 32'd1);
        check("t3_bursts", 32'(gq.size()), 32'd8);
        for (int k = 0; k < 5; k++)
            if (k < gq.size()) check("t3_grant_seq", 32'(gq[k]), 32'(t3_exp[k]));

        // wfull held for 5 cycles after word 2
        do_reset();
        en[0]  = 1'b1;
        lim[0] = n[0] + 4;
        cnt    = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge wclk);
            if (wr_en) cnt++;
            if (cnt == 2) break;
            step();
        end
        force_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            @(negedge wclk);
            check("t4_stall_wr_en", 32'(wr_en), 32'd0);
            check("t4_stall_ready", 32'(req_ready), 32'd0);
            check("t4_grant_held", 32'(grant), 32'd1);
        end
        force_full = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            @(negedge wclk);
            if (wr_en) cnt++;
        end
        step();
        check("t4_words", 32'(cnt), 32'd4);

        // Requester 2 drops valid after one word while 1 and 3 wait
        do_reset();
        en[2]  = 1'b1;
        lim[2] = n[2] + 4;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge wclk);
            if (wr_en) break;
            step();
        end
        check("t5_first_grant", 32'(grant), 32'b0100);
        en[2]  = 1'b0;
        en[1]  = 1'b1;
        en[3]  = 1'b1;
        lim[1] = n[1] + 4;
        lim[3] = n[3] + 4;
        step();
        @(negedge wclk);
        check("t5_drop_no_write", 32'(wr_en), 32'd0);
        prev  = grant;
        en[2] = 1'b1;
        step();
        gq.delete();
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge wclk);
            if (grant != '0 && prev == '0) gq.push_back(grant);
            prev = grant;
            step();
            if (gq.size() == 3) break;
        end
        check("t5_grants", 32'(gq.size()), 32'd3);
        for (int k = 0; k < 3; k++)
            if (k < gq.size()) check("t5_grant_seq", 32'(gq[k]), 32'(t5_exp[k]));

        // Reset pulse mid-burst after word 2
        do_reset();
        en[0]  = 1'b1;
        lim[0] = n[0] + 8;
        cnt    = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge wclk);
            if (wr_en) cnt++;
            if (cnt == 2) break;
            step();
        end
        step();
        #1;
        rst = 1'b1;
        #1;
        check("t6_grant_async", 32'(grant), 32'd0);
        check("t6_wr_en_async", 32'(wr_en), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        step();
        rst = 1'b0;
        @(negedge wclk);
        check("t6_release_idle", 32'(grant), 32'd0);
        step();
        @(negedge wclk);
        check("t6_first_grant", 32'(grant), 32'd1);
        step();

        // Fill the 13-deep FIFO from two requesters, then drain
        do_reset();
        drain_en = 1'b0;
        en[0]    = 1'b1;
        en[1]    = 1'b1;
        lim[0]   = n[0] + 20;
        lim[1]   = n[1] + 20;
        for (int k = 0; k < 40; k++) begin
            @(negedge wclk);
            step();
        end
        check("t7_fill_count", 32'(act_q.size()), 32'd13);
        check("t7_wfull", 32'(wfull), 32'd1);
        drain_en = 1'b1;
        done     = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge wclk);
            step();
            done = (mdl_q.size() == 0) && (n[0] >= lim[0]) && (n[1] >= lim[1]);
        end
        check("t7_drained", 32'(done), 32'd1);

        // Randomized traffic
        do_reset();
        rand_mode = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge wclk);
            step();
        end
        rand_mode  = 1'b0;
        force_full = 1'b0;
        for (int i = 0; i < N; i++) en[i] = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge wclk);
            step();
            if (mdl_q.size() == 0) break;
        end
        check("t8_model_empty", 32'(mdl_q.size()), 32'd0);
        check("t8_fifo_empty", 32'(act_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
